traffic_phase_scheduler: RTL and testbench
==========================================

Name: traffic_phase_scheduler

Overview:
- Master sequencer for the four-way intersection.
- Each cycle it decides which light configuration is active and drives the 5-bit `state1` phase code that the light drivers and red-light camera logic consume.
- Arbitrates between waiting-car sensors on all eight approaches (N/S/E/W straight and left) using min/max green timers, a fixed yellow interval and round-robin phase selection.

Parameters:
- GREEN_MIN, 8: minimum green length in cycles.
- GREEN_MAX, 30: maximum green length in cycles when a conflicting request is waiting.
- YELLOW_T, 4: yellow length in cycles.
- CNT_W, 6: timer width. Must hold max(GREEN_MAX, YELLOW_T) - 1.

Ports:
- CLK  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- n_waiting, s_waiting, e_waiting, w_waiting  in  1 each  car waiting at the straight lane, level.
- n_waitingL, s_waitingL, e_waitingL, w_waitingL  in  1 each  car waiting at the left-turn lane, level.
- state1  out  5  current phase code.
- phase_idx  out  3  round-robin index of the current green phase.
- yellow  out  1  high while `state1` is a yellow code.
- green_start  out  1  one-cycle pulse on the first cycle of each new green.

Behaviour:
- Green phases, as index:code:covered requests.
  - 0: n_s 00000: n, s.
  - 1: sl_nl 01100: sL, nL.
  - 2: n_nl 00100: n, nL.
  - 3: s_sl 00110: s, sL.
  - 4: e_w 00001: e, w.
  - 5: el_wl 01110: eL, wL.
  - 6: w_wl 01000: w, wL.
  - 7: e_el 01010: e, eL.
- Yellow codes: n_s→00010, e_w→00011; every other green code → code+1 (e.g. 01100→01101).
- FSM states: GREEN, YELLOW.
- Reset (`rst`=0, asynchronous, also mid-phase): state=GREEN, state1=00000, phase_idx=0, timer=0, yellow=0, green_start=0. No green_start pulse after reset.
- Timer: cleared on entry to each state, increments once per cycle, saturates at GREEN_MAX-1 in GREEN.
- Request classes:
  - own_req: any request covered by the current phase.
  - other_req: any request not covered by the current phase.
- GREEN exit: at the clock edge where either condition holds, go to YELLOW:
  - (timer ≥ GREEN_MIN-1 and other_req and !own_req), or
  - (timer ≥ GREEN_MAX-1 and other_req).
- If other_req=0, stay GREEN indefinitely.
- Green is therefore visible for at least GREEN_MIN cycles.
- YELLOW:
  - Lasts exactly YELLOW_T cycles.
  - At the edge where timer = YELLOW_T-1, select the next phase and enter GREEN.
  - green_start=1 for that first green cycle.
- Next-phase arbiter:
  - Search indices (cur+1 … cur+7) mod 8 and pick the first phase covering at least one request not covered by cur. Requests are sampled on the selection cycle.
  - If none qualify (requests withdrawn during yellow), pick (cur+1) mod 8.
  - The current phase is never reselected directly.
- Simultaneous events:
  - A request dropping on the same edge as the exit check uses the sampled value of that edge.
  - Reset overrides everything.
- Outputs are registered. state1 changes only on CLK edges or asynchronous reset.

Optional Feature:
- Macro: EMERGENCY_PREEMPT_EN.
- When defined, adds two ports:
  - preempt  in  1  emergency vehicle request.
  - preempt_idx  in  3  green phase index to force.
- Behaviour with the macro:
  - preempt=1 in GREEN with phase_idx≠preempt_idx → YELLOW next edge, ignoring GREEN_MIN.
  - At yellow end, the selected phase is preempt_idx, overriding the arbiter.
  - While preempt=1 and phase_idx=preempt_idx, stay GREEN (no exit).
  - preempt=1 during YELLOW does not shorten the yellow.
- Without the macro: ports absent; the arbiter alone governs.

Test Plan:
1. Reset, then e_waiting=1 only → state1=00000 for 8 cycles, 00010 for 4 cycles, then 00001 with green_start pulse, phase_idx=4.
2. In n_s, hold n_waiting=1 and w_waitingL=1 → green max-out: 00000 for 30 cycles, 00010 for 4, then 00101? No: the arbiter picks index 5 el_wl → state1=01110.
3. No requests for 100 cycles after reset → state1 stays 00000, yellow=0, no green_start.
4. In e_el (01010) at timer=3, assert s_waitingL; drop e requests → green held until timer=7, yellow 01011 for 4 cycles, arbiter wraps 7→0..: picks index 1 sl_nl → 01100.
5. Assert rst=0 mid-yellow (state1=00111) → state1=00000, timer=0 immediately, without waiting for CLK.
6. EMERGENCY_PREEMPT_EN: in n_s timer=2, preempt=1, preempt_idx=6 → 00010 next edge, 4 cycles, then 01000; held while preempt=1 despite other requests.

Source files
------------

// File: rtl/traffic_phase_scheduler.sv
// Purpose: four-way intersection phase sequencer (8 green phases, fixed yellow, round-robin arbiter).
// Latency: outputs are registered; a decision sampled at one CLK edge is visible right after that edge.
// Backpressure: none; sensors are level inputs. Optional EMERGENCY_PREEMPT_EN adds emergency preemption.
module traffic_phase_scheduler #(
  parameter int GREEN_MIN = 8,
  parameter int GREEN_MAX = 30,
  parameter int YELLOW_T  = 4,
  parameter int CNT_W     = 6
) (
  input  logic       CLK,
  input  logic       rst,
`ifdef EMERGENCY_PREEMPT_EN
  input  logic       preempt,
  input  logic [2:0] preempt_idx,
`endif
  input  logic       n_waiting,
  input  logic       s_waiting,
  input  logic       e_waiting,
  input  logic       w_waiting,
  input  logic       n_waitingL,
  input  logic       s_waitingL,
  input  logic       e_waitingL,
  input  logic       w_waitingL,
  output logic [4:0] state1,
  output logic [2:0] phase_idx,
  output logic       yellow,
  output logic       green_start
);

  typedef enum logic {GREEN = 1'b0, YELLOW = 1'b1} state_t;

  localparam logic [CNT_W-1:0] GMIN_LAST = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GMAX_LAST = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(YELLOW_T - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] timer, timer_nxt;
  logic [7:0]       req;
  logic [7:0]       own_mask;
  logic             own_req, other_req;
  logic             normal_exit, green_exit, yellow_done;
  logic [2:0]       arb_idx, sel_idx, phase_nxt;
  logic [4:0]       state1_nxt;
  logic             yellow_nxt, green_start_nxt;

  // Request bit order: n, s, e, w, nL, sL, eL, wL
  assign req = {w_waitingL, e_waitingL, s_waitingL, n_waitingL,
                w_waiting, e_waiting, s_waiting, n_waiting};

  // Requests served by each green phase
  function automatic logic [7:0] cover_mask(input logic [2:0] idx);
    case (idx)
      3'd0:    cover_mask = 8'b0000_0011; // n, s
      3'd1:    cover_mask = 8'b0011_0000; // sL, nL
      3'd2:    cover_mask = 8'b0001_0001; // n, nL
      3'd3:    cover_mask = 8'b0010_0010; // s, sL
      3'd4:    cover_mask = 8'b0000_1100; // e, w
      3'd5:    cover_mask = 8'b1100_0000; // eL, wL
      3'd6:    cover_mask = 8'b1000_1000; // w, wL
      default: cover_mask = 8'b0100_0100; // e, eL
    endcase
  endfunction

  // Green light code for each phase
  function automatic logic [4:0] green_code(input logic [2:0] idx);
    case (idx)
      3'd0:    green_code = 5'b00000;
      3'd1:    green_code = 5'b01100;
      3'd2:    green_code = 5'b00100;
      3'd3:    green_code = 5'b00110;
      3'd4:    green_code = 5'b00001;
      3'd5:    green_code = 5'b01110;
      3'd6:    green_code = 5'b01000;
      default: green_code = 5'b01010;
    endcase
  endfunction

  // Yellow code: the two through-traffic phases have dedicated codes, the rest are green+1
  function automatic logic [4:0] yellow_code(input logic [2:0] idx);
    case (idx)
      3'd0:    yellow_code = 5'b00010;
      3'd4:    yellow_code = 5'b00011;
      default: yellow_code = green_code(idx) + 5'd1;
    endcase
  endfunction

  assign own_mask    = cover_mask(phase_idx);
  assign own_req     = |(req & own_mask);
  assign other_req   = |(req & ~own_mask);
  assign yellow_done = (timer == YEL_LAST);
  assign normal_exit = other_req &&
                       (((timer >= GMIN_LAST) && !own_req) || (timer >= GMAX_LAST));

  // Round-robin search for the first later phase serving a request the current phase does not
  always_comb begin
    logic       found;
    logic [2:0] cand;
    arb_idx = phase_idx + 3'd1;
    found   = 1'b0;
    cand    = '0;
    for (int k = 1; k < 8; k++) begin
      cand = phase_idx + 3'(k);
      if (!found && |(req & ~own_mask & cover_mask(cand))) begin
        arb_idx = cand;
        found   = 1'b1;
      end
    end
  end

`ifdef EMERGENCY_PREEMPT_EN
  logic       pre_pend;
  logic [2:0] pre_tgt;
  logic       pre_force, pre_hold;

  assign pre_force  = preempt && (preempt_idx != phase_idx);
  assign pre_hold   = preempt && (preempt_idx == phase_idx);
  assign green_exit = pre_force || (!pre_hold && normal_exit);
  assign sel_idx    = preempt ? preempt_idx : (pre_pend ? pre_tgt : arb_idx);

  // Remember the emergency target so a request that drops during yellow still lands on it
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      pre_pend <= 1'b0;
      pre_tgt  <= '0;
    end else if (state == YELLOW && yellow_done) begin
      pre_pend <= 1'b0;
    end else if (preempt && (state == YELLOW || green_exit)) begin
      pre_pend <= 1'b1;
      pre_tgt  <= preempt_idx;
    end
  end
`else
  assign green_exit = normal_exit;
  assign sel_idx    = arb_idx;
`endif

  // State and registered outputs
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state       <= GREEN;
      timer       <= '0;
      phase_idx   <= '0;
      state1      <= 5'b00000;
      yellow      <= 1'b0;
      green_start <= 1'b0;
    end else begin
      state       <= state_nxt;
      timer       <= timer_nxt;
      phase_idx   <= phase_nxt;
      state1      <= state1_nxt;
      yellow      <= yellow_nxt;
      green_start <= green_start_nxt;
    end
  end

  // Next-state decision
  always_comb begin
    state_nxt = state;
    case (state)
      GREEN:   if (green_exit)  state_nxt = YELLOW;
      YELLOW:  if (yellow_done) state_nxt = GREEN;
      default: state_nxt = GREEN;
    endcase
  end

  // Next values of timer, phase and light outputs
  always_comb begin
    timer_nxt       = timer;
    phase_nxt       = phase_idx;
    state1_nxt      = state1;
    yellow_nxt      = yellow;
    green_start_nxt = 1'b0;
    case (state)
      GREEN: begin
        if (green_exit) begin
          timer_nxt  = '0;
          state1_nxt = yellow_code(phase_idx);
          yellow_nxt = 1'b1;
        end else if (timer != GMAX_LAST) begin
          timer_nxt = timer + 1'b1;
        end
      end
      YELLOW: begin
        if (yellow_done) begin
          timer_nxt       = '0;
          phase_nxt       = sel_idx;
          state1_nxt      = green_code(sel_idx);
          yellow_nxt      = 1'b0;
          green_start_nxt = 1'b1;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      default: timer_nxt = '0;
    endcase
  end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Purpose: directed + random stimulus against a cycle-level model of the intersection rules.
// Latency: model advances at each rising edge; DUT outputs compared 1 time unit later.
// Backpressure: none; every step applies one request vector.
module tb_traffic_phase_scheduler;

  localparam int GMIN = 8;
  localparam int GMAX = 30;
  localparam int YT   = 4;

  logic       CLK = 1'b0;
  logic       rst;
  logic [7:0] rq;
  logic [4:0] state1;
  logic [2:0] phase_idx;
  logic       yellow;
  logic       green_start;

  int n_vec = 0;
  int n_err = 0;

  // Model state: which light is on, which phase, cycles spent in the current light
  bit m_green;
  int m_ph;
  int m_el;
  bit m_gs;

  logic [7:0] cov [8] = '{8'h03, 8'h30, 8'h11, 8'h22, 8'h0C, 8'hC0, 8'h88, 8'h44};
  logic [4:0] gcode [8] = '{5'b00000, 5'b01100, 5'b00100, 5'b00110,
                            5'b00001, 5'b01110, 5'b01000, 5'b01010};

  always #5 CLK = ~CLK;

  traffic_phase_scheduler dut (
    .CLK         (CLK),
    .rst         (rst),
`ifdef EMERGENCY_PREEMPT_EN
    .preempt     (1'b0),
    .preempt_idx (3'd0),
`endif
    .n_waiting   (rq[0]),
    .s_waiting   (rq[1]),
    .e_waiting   (rq[2]),
    .w_waiting   (rq[3]),
    .n_waitingL  (rq[4]),
    .s_waitingL  (rq[5]),
    .e_waitingL  (rq[6]),
    .w_waitingL  (rq[7]),
    .state1      (state1),
    .phase_idx   (phase_idx),
    .yellow      (yellow),
    .green_start (green_start)
  );

  function automatic logic [4:0] ycode(input int ph);
    if (ph == 0)      return 5'b00010;
    else if (ph == 4) return 5'b00011;
    else              return gcode[ph] + 5'd1;
  endfunction

  task automatic model_reset();
    m_green = 1'b1;
    m_ph    = 0;
    m_el    = 0;
    m_gs    = 1'b0;
  endtask

  task automatic model_edge(input logic [7:0] r);
    bit own, other, found;
    int nxt;
    if (m_green) begin
      own   = (r & cov[m_ph]) != 8'h00;
      other = (r & ~cov[m_ph]) != 8'h00;
      if (other && ((m_el >= GMIN - 1 && !own) || m_el >= GMAX - 1)) begin
        m_green = 1'b0;
        m_el    = 0;
      end else begin
        m_el++;
      end
      m_gs = 1'b0;
    end else if (m_el == YT - 1) begin
      nxt   = (m_ph + 1) % 8;
      found = 1'b0;
      for (int k = 1; k < 8; k++) begin
        if (!found && ((r & ~cov[m_ph] & cov[(m_ph + k) % 8]) != 8'h00)) begin
          nxt   = (m_ph + k) % 8;
          found = 1'b1;
        end
      end
      m_ph    = nxt;
      m_green = 1'b1;
      m_el    = 0;
      m_gs    = 1'b1;
    end else begin
      m_el++;
      m_gs = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("state1", 32'(state1), m_green ? 32'(gcode[m_ph]) : 32'(ycode(m_ph)));
    chk("phase_idx", 32'(phase_idx), 32'(m_ph));
    chk("yellow", 32'(yellow), 32'(!m_green));
    chk("green_start", 32'(green_start), 32'(m_gs));
  endtask

  task automatic step(input logic [7:0] r);
    rq = r;
    @(posedge CLK);
    model_edge(r);
    #1;
    check_all();
  endtask

  // Reset asserted between edges; outputs must clear before any clock edge arrives
  task automatic do_reset();
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_all();
    repeat (2) @(posedge CLK);
    #1;
    check_all();
    rst = 1'b1;
  endtask

  initial begin
    int n;
    rst = 1'b0;
    rq  = 8'h00;
    model_reset();
    #2;
    check_all();
    repeat (2) @(posedge CLK);
    #1;
    rst = 1'b1;

    // Idle intersection stays in n_s green
    repeat (100) step(8'h00);

    // East car only: 8 green, 4 yellow, then e_w
    do_reset();
    repeat (12) step(8'h04);
    chk("t1_state1", 32'(state1), 32'h01);
    chk("t1_phase", 32'(phase_idx), 32'd4);
    chk("t1_gstart", 32'(green_start), 32'd1);

    // North held plus west-left: max-out after 30 cycles, arbiter lands on el_wl
    do_reset();
    repeat (34) step(8'h81);
    chk("t2_state1", 32'(state1), 32'h0E);
    chk("t2_phase", 32'(phase_idx), 32'd5);

    // Reach e_el with timer at 3, then switch demand to south-left
    n = 0;
    do begin
      step(8'h04);
      n++;
    end while (!(m_green && m_ph == 7 && m_el == 3) && n < 200);
    chk("t4_reach", 32'(n < 200), 32'd1);
    repeat (20) step(8'h20);
    chk("t4_state1", 32'(state1), 32'h0C);
    chk("t4_phase", 32'(phase_idx), 32'd1);

    // Asynchronous reset in the middle of a yellow
    n = 0;
    do begin
      step(8'h01);
      n++;
    end while (!(!m_green && m_el == 1) && n < 100);
    chk("t5_reach", 32'(n < 100), 32'd1);
    chk("t5_yellow", 32'(yellow), 32'd1);
    do_reset();

    // Random sparse demand patterns
    rq = 8'h00;
    for (int i = 0; i < 1500; i++) begin
      logic [7:0] r;
      r = rq;
      if ($urandom_range(0, 7) == 0) r = 8'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 399) == 0) do_reset();
      step(r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
